// File: rtl/seq_mult_pkg.sv
// Shared types and derived-width helper for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Conditional two's-complement negate; gives |x| for operands and applies the product sign.
module seq_mult_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? ((~x) + W'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier with signed/unsigned mode and valid/ready handshakes.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    state_t               state, state_next;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc, acc_next;
    logic                 neg;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   p_fix;
    logic                 accept;
    logic                 last_iter;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    seq_mult_abs #(.W(WIDTH)) u_abs_a (
        .x   (a),
        .neg (signed_mode & a[WIDTH-1]),
        .y   (a_mag)
    );

    seq_mult_abs #(.W(WIDTH)) u_abs_b (
        .x   (b),
        .neg (signed_mode & b[WIDTH-1]),
        .y   (b_mag)
    );

    seq_mult_abs #(.W(2*WIDTH)) u_sign_fix (
        .x   (acc_next),
        .neg (neg),
        .y   (p_fix)
    );

    // Upper half accumulates with its carry; the multiplier bits drain out of the lower half.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= a_mag;
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) p <= p_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic       iv4, ir4, sm4, ov4, or4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        iv8, ir8, sm8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned last_acc = 0;
    bit have_prev = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: interpret operands as integers and multiply, keeping 2*w bits.
    function automatic longint ref_mul(input int w, input longint a, input longint b, input bit sm);
        longint sa = a;
        longint sb = b;
        if (sm) begin
            if (a >= (longint'(1) << (w - 1))) sa = a - (longint'(1) << w);
            if (b >= (longint'(1) << (w - 1))) sb = b - (longint'(1) << w);
        end
        return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic drive(input bit w8, input bit v, input logic [7:0] a, input logic [7:0] b, input bit sm);
        if (w8) begin
            iv8 = v; a8 = a; b8 = b; sm8 = sm;
        end else begin
            iv4 = v; a4 = a[3:0]; b4 = b[3:0]; sm4 = sm;
        end
    endtask

    task automatic set_or(input bit w8, input bit v);
        if (w8) or8 = v; else or4 = v;
    endtask

    function automatic bit get_ov(input bit w8);
        return w8 ? ov8 : ov4;
    endfunction

    function automatic bit get_ir(input bit w8);
        return w8 ? ir8 : ir4;
    endfunction

    function automatic longint get_p(input bit w8);
        return w8 ? longint'(p8) : longint'(p4);
    endfunction

    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b, input bit sm,
                          input int hold, input bit chk_hold, input string tag);
        int     w;
        int     n;
        int     lat;
        longint exp;
        w   = w8 ? 8 : 4;
        exp = w8 ? ref_mul(8, longint'(a), longint'(b), sm)
                 : ref_mul(4, longint'(a[3:0]), longint'(b[3:0]), sm);
        n = 0;
        while (!get_ir(w8) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " ready"}, longint'(get_ir(w8)), 1);
        drive(w8, 1'b1, a, b, sm);
        @(posedge clk); #1;
        if (w8) begin
            if (have_prev) check({tag, " interval"}, longint'((cycle - last_acc) >= 10), 1);
            last_acc  = cycle;
            have_prev = 1'b1;
        end
        drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        lat = 0;
        while (!get_ov(w8) && lat < 200) begin
            @(posedge clk); #1; lat++;
            drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        check({tag, " latency"}, longint'(lat), longint'(w));
        check({tag, " product"}, get_p(w8), exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (chk_hold) begin
                check({tag, " hold ov"}, longint'(get_ov(w8)), 1);
                check({tag, " hold p"}, get_p(w8), exp);
                check({tag, " hold ir"}, longint'(get_ir(w8)), 0);
            end
        end
        set_or(w8, 1'b1);
        @(posedge clk); #1;
        set_or(w8, 1'b0);
        check({tag, " ov drop"}, longint'(get_ov(w8)), 0);
        check({tag, " p kept"}, get_p(w8), exp);
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        drive(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
        or4 = 1'b0;
        or8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst ir8", longint'(ir8), 1);
        check("rst ov8", longint'(ov8), 0);
        check("rst p8", longint'(p8), 0);
        check("rst busy8", longint'(busy8), 0);
        check("rst ir4", longint'(ir4), 1);
        check("rst p4", longint'(p4), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 8'hF, 8'hF, 1'b0, 0, 1'b0, "u4 15x15");
        run_op(1'b0, 8'hD, 8'hB, 1'b0, 0, 1'b0, "u4 13x11");
        run_op(1'b0, 8'h8, 8'h8, 1'b1, 0, 1'b0, "s4 -8x-8");
        run_op(1'b0, 8'h8, 8'h7, 1'b1, 0, 1'b0, "s4 -8x7");
        run_op(1'b0, 8'hF, 8'h1, 1'b1, 0, 1'b0, "s4 -1x1");

        run_op(1'b1, 8'h00, 8'h80, 1'b1, 0, 1'b0, "s8 0x-128");
        run_op(1'b1, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, "u8 255x255");
        run_op(1'b1, 8'h80, 8'h80, 1'b1, 0, 1'b0, "s8 -128x-128");
        run_op(1'b1, 8'h9C, 8'h37, 1'b1, 10, 1'b1, "bp");

        // Abort two iterations into an operation.
        drive(1'b1, 1'b1, 8'h55, 8'h77, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mid busy", longint'(busy8), 1);
        rst_n = 1'b0;
        #1;
        check("abort ov", longint'(ov8), 0);
        check("abort p", longint'(p8), 0);
        check("abort busy", longint'(busy8), 0);
        check("abort ir", longint'(ir8), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        have_prev = 1'b0;
        run_op(1'b1, 8'd3, 8'd5, 1'b0, 0, 1'b0, "post rst 3x5");

        for (int k = 0; k < 100; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 8'h80;
                1: rb = 8'h00;
                2: begin ra = 8'hFF; rb = 8'h80; end
                default: ;
            endcase
            run_op(1'b1, ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier. It is the multi-cycle successor to the team's fixed 4x4 combinational array multiplier. It adds configurable operand width, a per-operation signed/unsigned mode, and valid/ready handshakes on input and output. It trades latency for area and sits in datapaths that need wide products without a full array.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product width is 2*WIDTH
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = a, b two's complement; 0 = unsigned; sampled with operands
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
p  output  2*WIDTH  product
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async assert, sync deassert by the driver): state=IDLE, p=0, out_valid=0, busy=0, in_ready=1, counter=0, internal registers=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch operands and go to BUSY.
  - BUSY: one iteration per clock, WIDTH iterations.
  - DONE: out_valid=1 and p stable. On out_ready, go to IDLE.
- Decoupling: in_ready=(state==IDLE); out_valid=(state==DONE). No new accept in the DONE cycle, even if out_ready is high.
- Operand capture:
  - Unsigned: magnitudes are a and b as given.
  - Signed: magnitude is |x| as WIDTH-bit unsigned. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits.
  - Latch neg = signed_mode & (a[WIDTH-1]^b[WIDTH-1]).
- Iteration (radix-2, LSB first): if the multiplier LSB is 1, add the multiplicand into the upper accumulator half, with carry kept in a WIDTH+1-bit add. Then shift the accumulator right 1 and increment the counter.
- On the WIDTH-th iteration edge, p <= neg ? two's-complement negation of the accumulator : accumulator, and state becomes DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge. Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- Result width: the full 2*WIDTH product, never truncated.
  - Signed: -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2), representable.
  - Zero operand: product 0 and never -0; negating 0 yields 0.
- Back-pressure: DONE is held indefinitely with p stable until out_ready.
- After a handshake, p retains the last product; only out_valid drops.
- Inputs a, b, signed_mode are ignored outside the accepting cycle. Changing them in BUSY has no effect.
- Reset mid-operation aborts immediately to the reset values. No partial product ever appears with out_valid=1.
- X on in_valid while IDLE is a bench error; the design need not tolerate it.

Decomposition:
- Package seq_mult_pkg:
  - state_t enum {IDLE, BUSY, DONE}
  - localparam helper for CNT_W
- One natural sub-module: seq_mult_abs, a combinational conditional two's-complement negate of parametrised width, used for both operand magnitudes and the final sign fix. The rest stays in one always_ff plus one next-state block.

Test Plan:
1. WIDTH=4, unsigned, a=15, b=15 -> p=8'hE1 (225), out_valid exactly 4 edges after accept; repeat with a=13, b=11 -> 8'h8F (143).
2. WIDTH=4, signed, a=4'h8, b=4'h8 (-8*-8) -> 8'h40; a=4'h8, b=4'h7 -> 8'hC8 (-56); a=4'hF, b=4'h1 -> 8'hFF.
3. WIDTH=8, signed, a=0, b=8'h80 -> 16'h0000; unsigned a=8'hFF, b=8'hFF -> 16'hFE01.
4. Back-pressure: out_ready=0 for 10 cycles after DONE -> out_valid and p held, in_ready=0. Operands toggled during BUSY must not alter p.
5. Reset mid-BUSY at iteration 2 -> all outputs at reset values next cycle. The next op (unsigned 3*5) yields 15 with normal latency.
6. Back-to-back: 100 random signed/unsigned ops at WIDTH=8 with random out_ready -> every p matches the reference model; issue interval >= WIDTH+2.
